lane_block_scheduler: RTL

- Sequences the falling note blocks for one key lane (F, G, H or J). The top level instantiates four of these, one per lane.
- Owns six block-position slots. Each slot holds the block's bottom-edge height in the same coordinate space the pixel generator draws.
- Spawns blocks on request, advances them once per video frame, and judges key presses against the hit zone below the judgement line.
- Produces the per-lane `wrong` flag, plus hit/miss pulses for scoring.

---
 rtl/lane_block_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lane_block_scheduler.sv
// Falling-block scheduler for one key lane: spawns, advances and judges up to six blocks,
// and raises hit/miss pulses plus a timed wrong flag for the pixel generator.
module lane_block_scheduler #(
  parameter int unsigned SPAWN_H      = 120,
  parameter int unsigned HIT_LO       = 468,
  parameter int unsigned HIT_HI       = 599,
  parameter int unsigned BASE_STEP    = 2,
  parameter int unsigned WRONG_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        frame_tick,
  input  logic [1:0]  level,
  input  logic        spawn_req,
  input  logic        key_press,
  output logic [59:0] blk_h,
  output logic [2:0]  active_cnt,
  output logic        wrong,
  output logic        hit,
  output logic        miss,
  output logic        overflow,
  output logic [1:0]  state
);

  localparam int unsigned NSLOT = 6;
  localparam int unsigned HW    = 10;
  localparam int unsigned AW    = HW + 1;
  localparam int unsigned IW    = 3;
  localparam int unsigned CW    = $clog2(WRONG_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [HW-1:0]   h_q [NSLOT];
  logic [HW-1:0]   h_n [NSLOT];
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            ovf_q, ovf_n;
  logic            hit_q, hit_n;
  logic            miss_q, miss_n;
  logic            wrong_q;
  logic [2:0]      active_q, active_n;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [HW-1:0]   win_h;
  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic            reload;
  logic [AW-1:0]   adv;

  // Judge winner and first free slot, both taken from start-of-cycle positions
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_h      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (h_q[i] != '0 && h_q[i] >= HW'(HIT_LO) && h_q[i] <= HW'(HIT_HI) &&
          (!win_found || h_q[i] > win_h)) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_h     = h_q[i];
      end
      if (h_q[i] == '0 && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Next-state: commands first, then judge / advance / spawn on disjoint slots
  always_comb begin
    state_n  = state_q;
    h_n      = h_q;
    cnt_n    = cnt_q;
    ovf_n    = ovf_q;
    hit_n    = 1'b0;
    miss_n   = 1'b0;
    reload   = 1'b0;
    adv      = '0;
    active_n = '0;

    if (stop) begin
      for (int i = 0; i < NSLOT; i++) h_n[i] = '0;
      ovf_n   = 1'b0;
      state_n = S_IDLE;
    end else if (start) begin
      for (int i = 0; i < NSLOT; i++) h_n[i] = '0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
      state_n = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_n = S_PAUSED;
          end else begin
            if (key_press) begin
              if (win_found) hit_n = 1'b1;
              else           reload = 1'b1;
            end
            for (int i = 0; i < NSLOT; i++) begin
              if (key_press && win_found && win_idx == IW'(i)) begin
                h_n[i] = '0;
              end else if (frame_tick && h_q[i] != '0) begin
                adv = AW'(h_q[i]) + AW'(BASE_STEP) + AW'(level);
                if (adv > AW'(HIT_HI)) begin
                  h_n[i] = '0;
                  miss_n = 1'b1;
                  reload = 1'b1;
                end else begin
                  h_n[i] = adv[HW-1:0];
                end
              end
            end
            if (spawn_req) begin
              if (free_found) begin
                for (int i = 0; i < NSLOT; i++)
                  if (free_idx == IW'(i)) h_n[i] = HW'(SPAWN_H);
              end else begin
                ovf_n = 1'b1;
              end
            end
            if (reload)                          cnt_n = CW'(WRONG_FRAMES);
            else if (frame_tick && cnt_q != '0)  cnt_n = cnt_q - CW'(1);
          end
        end
        S_PAUSED: if (!pause) state_n = S_RUN;
        default:  state_n = S_IDLE;
      endcase
    end

    for (int i = 0; i < NSLOT; i++)
      if (h_n[i] != '0) active_n = active_n + 3'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < NSLOT; i++) h_q[i] <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      wrong_q  <= 1'b0;
      active_q <= '0;
    end else begin
      state_q  <= state_n;
      h_q      <= h_n;
      cnt_q    <= cnt_n;
      ovf_q    <= ovf_n;
      hit_q    <= hit_n;
      miss_q   <= miss_n;
      wrong_q  <= (cnt_n != '0);
      active_q <= active_n;
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_pack
    assign blk_h[HW*g +: HW] = h_q[g];
  end

  assign active_cnt = active_q;
  assign wrong      = wrong_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign overflow   = ovf_q;
  assign state      = state_q;

endmodule
